// File: rtl/norm2_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : norm2_mul_pkg
//  Description : Shared types and arithmetic helpers for the norm2 pipelined
//                multiplier: product sizing, clamp bounds and the
//                round-half-up / saturate step.
//  Revision    : 1.0 - initial release
// ============================================================================
package norm2_mul_pkg;

   // Working width for rounding/saturation; wide enough for any legal
   // operand and output width combination of this block.
   localparam int MAX_W = 128;

   localparam logic signed [MAX_W-1:0] c_ONE  = {{(MAX_W-1){1'b0}}, 1'b1};
   localparam logic signed [MAX_W-1:0] c_ZERO = '0;

   typedef struct packed {
      logic             sat;
      logic [MAX_W-1:0] val;
   } sat_res_t;

   // Full signed product width for (w0+1) x (w1+1) extended operands.
   function automatic int prod_width(input int w0, input int w1);
      return w0 + w1 + 2;
   endfunction

   // Upper clamp bound for a signed or unsigned result of width dw.
   function automatic logic signed [MAX_W-1:0] clamp_hi(input logic signed_res, input int dw);
      return signed_res ? (c_ONE <<< (dw - 1)) - c_ONE : (c_ONE <<< dw) - c_ONE;
   endfunction

   // Lower clamp bound for a signed or unsigned result of width dw.
   function automatic logic signed [MAX_W-1:0] clamp_lo(input logic signed_res, input int dw);
      return signed_res ? -(c_ONE <<< (dw - 1)) : c_ZERO;
   endfunction

   // Round-half-up arithmetic right shift followed by clamping.
   function automatic sat_res_t sat_round(input logic signed [MAX_W-1:0] p,
                                          input logic signed_res,
                                          input int shift,
                                          input int dout_w);
      logic signed [MAX_W-1:0] r;
      logic signed [MAX_W-1:0] hi;
      logic signed [MAX_W-1:0] lo;
      sat_res_t res;
      if (shift > 0) r = (p + (c_ONE <<< (shift - 1))) >>> shift;
      else           r = p;
      hi      = clamp_hi(signed_res, dout_w);
      lo      = clamp_lo(signed_res, dout_w);
      res.sat = 1'b0;
      res.val = r;
      if (r > hi) begin
         res.sat = 1'b1;
         res.val = hi;
      end else if (r < lo) begin
         res.sat = 1'b1;
         res.val = lo;
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/norm2_mul_stage.sv
`default_nettype none
// ============================================================================
//  Module      : norm2_mul_stage
//  Description : One pipeline slot: a valid bit plus a data word, loaded from
//                upstream whenever the slot is allowed to advance.
//  Revision    : 1.0 - initial release
// ============================================================================
module norm2_mul_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_adv,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // Load upstream contents when advancing, otherwise hold (stall).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_adv) begin
         r_valid <= i_valid;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/norm2_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : norm2_mul_pipe
//  Description : Pipelined signed/unsigned multiplier with round-half-up
//                shift and saturation, NUM_STAGE deep, valid/ready handshake.
//                Stage 0 holds the raw product, stage 1 the rounded and
//                clamped result (both in stage 0 when NUM_STAGE is 1), the
//                remaining stages are plain delay slots.
//  Revision    : 1.0 - initial release
// ============================================================================
module norm2_mul_pipe
   import norm2_mul_pkg::*;
#(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 3,
   parameter int din0_WIDTH = 44,
   parameter int din1_WIDTH = 6,
   parameter int dout_WIDTH = 50,
   parameter int SHIFT      = 0
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic [1:0]            in_signed,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  out_sat,
   output logic                  busy
);

   localparam int P_W = prod_width(din0_WIDTH, din1_WIDTH);
   // Shared stage word: MSB is a flag (result-signed in stage 0, sat later).
   localparam int D_W = ((P_W > dout_WIDTH) ? P_W : dout_WIDTH) + 1;

   logic signed [din0_WIDTH:0] w_a;
   logic signed [din1_WIDTH:0] w_b;
   logic signed [P_W-1:0]      w_prod;
   logic                       w_res_signed;
   logic signed [P_W-1:0]      w_rnd_p;
   logic                       w_rnd_sgn;
   sat_res_t                   w_rnd;
   logic [D_W-1:0]             w_raw;
   logic [D_W-1:0]             w_fin;
   logic [D_W-1:0]             w_s0_in;
   logic [NUM_STAGE-1:0]       w_v;
   logic [NUM_STAGE-1:0]       w_adv;
   logic [D_W-1:0]             w_d [NUM_STAGE];
   logic                       w_carry;
   logic                       w_unused;

   // Operand extension by per-operand signedness, then full signed multiply.
   assign w_a          = {in_signed[0] & din0[din0_WIDTH-1], din0};
   assign w_b          = {in_signed[1] & din1[din1_WIDTH-1], din1};
   assign w_prod       = P_W'(w_a) * P_W'(w_b);
   assign w_res_signed = |in_signed;
   assign w_raw        = {w_res_signed, (D_W-1)'(w_prod)};

   // With a single stage the rounding works on the fresh product.
   if (NUM_STAGE == 1) begin : g_merged
      assign w_rnd_p   = w_prod;
      assign w_rnd_sgn = w_res_signed;
      assign w_s0_in   = w_fin;
   end else begin : g_split
      assign w_rnd_p   = w_d[0][P_W-1:0];
      assign w_rnd_sgn = w_d[0][D_W-1];
      assign w_s0_in   = w_raw;
   end

   assign w_rnd = sat_round(MAX_W'(w_rnd_p), w_rnd_sgn, SHIFT, dout_WIDTH);
   assign w_fin = {w_rnd.sat, (D_W-1)'(w_rnd.val[dout_WIDTH-1:0])};

   // Advance chain: a slot may load if it is empty or its successor advances.
   always_comb begin
      w_adv   = '0;
      w_carry = ~w_v[NUM_STAGE-1] | out_ready;
      w_adv[NUM_STAGE-1] = w_carry;
      for (int k = NUM_STAGE - 2; k >= 0; k--) begin
         w_carry  = ~w_v[k] | w_carry;
         w_adv[k] = w_carry;
      end
   end

   for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
      logic           w_vin;
      logic [D_W-1:0] w_din;
      if (k == 0) begin : g_first
         assign w_vin = in_valid;
         assign w_din = w_s0_in;
      end else if (k == 1) begin : g_round
         assign w_vin = w_v[0];
         assign w_din = w_fin;
      end else begin : g_delay
         assign w_vin = w_v[k-1];
         assign w_din = w_d[k-1];
      end
      norm2_mul_stage #(.W(D_W)) u_stage (
         .clk     (ap_clk),
         .rst     (ap_rst),
         .i_adv   (w_adv[k]),
         .i_valid (w_vin),
         .i_data  (w_din),
         .o_valid (w_v[k]),
         .o_data  (w_d[k])
      );
   end

   assign in_ready  = w_adv[0] & ~ap_rst;
   assign out_valid = w_v[NUM_STAGE-1];
   assign dout      = w_d[NUM_STAGE-1][dout_WIDTH-1:0];
   assign out_sat   = w_v[NUM_STAGE-1] & w_d[NUM_STAGE-1][D_W-1];
   assign busy      = |w_v;

   // Bits of the shared stage word that a given configuration leaves idle.
   assign w_unused = ^{w_rnd, w_d[0], w_d[NUM_STAGE-1], w_raw, w_fin, ID};

endmodule
`default_nettype wire

// File: tb/tb_norm2_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_norm2_mul_pipe
//  Description : Scoreboard bench for norm2_mul_pipe. Four instances:
//                0: 8x8->8, SHIFT=4, 3 stages   1: defaults (44x6->50)
//                2: 8x8->8, SHIFT=4, 1 stage    3: 8x8->8, SHIFT=4, 8 stages
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_norm2_mul_pipe;

   typedef struct {
      logic [63:0] dout;
      logic        sat;
      logic        chk;
      int          acc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [3:0]  in_valid;
   logic [3:0]  out_ready;
   logic [63:0] din0 [4];
   logic [63:0] din1 [4];
   logic [1:0]  in_signed [4];
   wire  [3:0]  in_ready;
   wire  [3:0]  out_valid;
   wire  [3:0]  out_sat;
   wire  [3:0]  busy;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   logic tog_en  = 1'b0;
   logic [3:0] pat = 4'b1001;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar i = 0; i < 4; i++) begin : g_dut
      localparam int NS = (i == 2) ? 1 : (i == 3) ? 8 : 3;
      localparam int W0 = (i == 1) ? 44 : 8;
      localparam int W1 = (i == 1) ? 6 : 8;
      localparam int DW = (i == 1) ? 50 : 8;
      localparam int SH = (i == 1) ? 0 : 4;
      wire [DW-1:0] w_dout;
      exp_t q[$];
      int   occ = 0;

      norm2_mul_pipe #(
         .ID(i), .NUM_STAGE(NS), .din0_WIDTH(W0), .din1_WIDTH(W1),
         .dout_WIDTH(DW), .SHIFT(SH)
      ) u_dut (
         .ap_clk    (clk),
         .ap_rst    (rst),
         .in_valid  (in_valid[i]),
         .in_ready  (in_ready[i]),
         .din0      (din0[i][W0-1:0]),
         .din1      (din1[i][W1-1:0]),
         .in_signed (in_signed[i]),
         .out_valid (out_valid[i]),
         .out_ready (out_ready[i]),
         .dout      (w_dout),
         .out_sat   (out_sat[i]),
         .busy      (busy[i])
      );

      // Monitor: handshake model check plus in-order compare against queue head.
      always @(negedge clk) begin
         logic exp_rdy;
         #2;
         if (rst) begin
            occ = 0;
         end else begin
            exp_rdy = !((occ == NS) && !out_ready[i]);
            n_tests++;
            if (in_ready[i] !== exp_rdy) begin
               n_fail++;
               $display("FAIL in_ready dut%0d cyc %0d: got %b want %b", i, cyc, in_ready[i], exp_rdy);
            end
            n_tests++;
            if (busy[i] !== (occ != 0)) begin
               n_fail++;
               $display("FAIL busy dut%0d cyc %0d: got %b want %b", i, cyc, busy[i], (occ != 0));
            end
            if (out_valid[i]) begin
               n_tests++;
               if (q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected output dut%0d cyc %0d: got %h want none", i, cyc, w_dout);
               end else begin
                  if (64'(w_dout) !== q[0].dout || out_sat[i] !== q[0].sat) begin
                     n_fail++;
                     $display("FAIL result dut%0d cyc %0d: got %h/%b want %h/%b",
                              i, cyc, w_dout, out_sat[i], q[0].dout, q[0].sat);
                  end
                  if (out_ready[i]) begin
                     if (q[0].chk) begin
                        n_tests++;
                        if (cyc - q[0].acc != NS) begin
                           n_fail++;
                           $display("FAIL latency dut%0d: got %0d want %0d", i, cyc - q[0].acc, NS);
                        end
                     end
                     void'(q.pop_front());
                  end
               end
            end
            occ = occ + ((in_valid[i] && in_ready[i]) ? 1 : 0)
                      - ((out_valid[i] && out_ready[i]) ? 1 : 0);
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic push(input int d, input exp_t e);
      case (d)
         0: g_dut[0].q.push_back(e);
         1: g_dut[1].q.push_back(e);
         2: g_dut[2].q.push_back(e);
         default: g_dut[3].q.push_back(e);
      endcase
   endtask

   task automatic clear_queues();
      g_dut[0].q.delete();
      g_dut[1].q.delete();
      g_dut[2].q.delete();
      g_dut[3].q.delete();
   endtask

   // Present one beat and hold it until accepted; record expectation.
   task automatic send(input int d, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] sg, input logic [63:0] ed, input logic es,
                       input logic lat);
      exp_t e;
      int   guard;
      @(negedge clk);
      in_valid[d]  = 1'b1;
      din0[d]      = a;
      din1[d]      = b;
      in_signed[d] = sg;
      #1;
      guard = 0;
      while (!in_ready[d] && guard < 200) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!in_ready[d]) begin
         n_tests++;
         n_fail++;
         $display("FAIL send timeout dut%0d: got in_ready 0 want 1", d);
         in_valid[d] = 1'b0;
      end else begin
         e.dout = ed;
         e.sat  = es;
         e.chk  = lat;
         e.acc  = cyc;
         push(d, e);
         @(posedge clk);
      end
   endtask

   task automatic idle(input int d);
      @(negedge clk);
      in_valid[d] = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      do begin
         @(negedge clk);
         #3;
         guard++;
      end while ((g_dut[0].q.size() + g_dut[1].q.size() + g_dut[2].q.size()
                  + g_dut[3].q.size()) != 0 && guard < 500);
      n_tests++;
      if (guard >= 500) begin
         n_fail++;
         $display("FAIL drain timeout: got %0d pending want 0",
                  g_dut[0].q.size() + g_dut[1].q.size() + g_dut[2].q.size() + g_dut[3].q.size());
      end
   endtask

   // out_ready pattern 1,0,0,1 for instance 0 while enabled.
   initial begin
      int ti;
      ti = 0;
      forever begin
         @(negedge clk);
         if (tog_en) begin
            out_ready[0] = pat[ti];
            ti = (ti + 1) % 4;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = '0;
      out_ready = '1;
      for (int k = 0; k < 4; k++) begin
         din0[k]      = '0;
         din1[k]      = '0;
         in_signed[k] = '0;
      end
      repeat (2) @(negedge clk);
      #1;
      chk("reset out_valid", 64'(out_valid[0]), 0);
      chk("reset in_ready",  64'(in_ready[0]), 0);
      chk("reset busy",      64'(busy[0]), 0);
      chk("reset dout",      64'(g_dut[0].w_dout), 0);
      chk("reset out_sat",   64'(out_sat[0]), 0);
      @(negedge clk);
      rst = 1'b0;

      // Unsigned and signed rounding/saturation, 3-stage latency.
      send(0, 16,  3,   2'b00, 64'd3,    1'b0, 1'b1);
      send(0, 200, 100, 2'b00, 64'd255,  1'b1, 1'b1);
      send(0, 8'hFD, 5, 2'b11, 64'hFF,   1'b0, 1'b1);
      send(0, 8'h80, 8'h80, 2'b11, 64'h7F, 1'b1, 1'b1);
      idle(0);
      drain();

      // Ten beats under a stalling consumer.
      tog_en = 1'b1;
      for (int k = 1; k <= 10; k++) send(0, 64'(16 * k), 1, 2'b00, 64'(k), 1'b0, 1'b0);
      idle(0);
      drain();
      tog_en = 1'b0;
      @(negedge clk);
      out_ready[0] = 1'b1;

      // Default-parameter instance: full-width unsigned product.
      send(1, 64'h0000_0FFF_FFFF_FFFF, 63, 2'b00, 64'h0003_EFFF_FFFF_FFC1, 1'b0, 1'b1);
      send(1, 5, 7, 2'b00, 64'd35, 1'b0, 1'b1);
      idle(1);
      drain();

      // Single-stage and eight-stage latency and throughput.
      send(2, 16, 3, 2'b00, 64'd3, 1'b0, 1'b1);
      idle(2);
      drain();
      for (int k = 1; k <= 5; k++) send(2, 64'(16 * k), 1, 2'b00, 64'(k), 1'b0, 1'b1);
      idle(2);
      send(3, 16, 3, 2'b00, 64'd3, 1'b0, 1'b1);
      idle(3);
      drain();
      for (int k = 1; k <= 5; k++) send(3, 64'(16 * k), 1, 2'b00, 64'(k), 1'b0, 1'b1);
      idle(3);
      drain();

      // Asynchronous reset with a full, stalled pipe.
      @(negedge clk);
      out_ready[0] = 1'b0;
      send(0, 32, 1, 2'b00, 64'd2, 1'b0, 1'b0);
      send(0, 48, 1, 2'b00, 64'd3, 1'b0, 1'b0);
      send(0, 64, 1, 2'b00, 64'd4, 1'b0, 1'b0);
      idle(0);
      @(posedge clk);
      #2;
      chk("pre-reset out_valid", 64'(out_valid[0]), 1);
      rst = 1'b1;
      #1;
      chk("async rst out_valid", 64'(out_valid[0]), 0);
      chk("async rst busy",      64'(busy[0]), 0);
      chk("async rst dout",      64'(g_dut[0].w_dout), 0);
      chk("async rst in_ready",  64'(in_ready[0]), 0);
      clear_queues();
      @(negedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      out_ready[0] = 1'b1;
      send(0, 16, 3, 2'b00, 64'd3, 1'b0, 1'b1);
      idle(0);
      drain();
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/norm2_mul_pipe.md
Name: norm2_mul_pipe

Overview:
Parametrised, pipelined successor to the norm2 fixed-width multiplier, used in the LRN (norm2) datapath.
- Multiplies two operands; signedness is selectable per transaction.
- Applies an optional round-half-up right shift, then saturates to the output width.
- Carries results through NUM_STAGE registered stages with valid/ready backpressure, so the HLS-style scheduler can stall it.

Parameters:
ID, 1, instance tag; no functional effect
NUM_STAGE, 3, pipeline depth in cycles, legal range 1..8
din0_WIDTH, 44, operand 0 width
din1_WIDTH, 6, operand 1 width
dout_WIDTH, 50, result width after shift and saturation
SHIFT, 0, right shift applied to the full product, range 0..din0_WIDTH+din1_WIDTH-1

Ports:
ap_clk  in  1  clock; all state changes on the rising edge
ap_rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts a beat this cycle
din0  in  din0_WIDTH  operand 0
din1  in  din1_WIDTH  operand 1
in_signed  in  2  bit0: din0 signed; bit1: din1 signed
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
dout  out  dout_WIDTH  shifted, saturated product
out_sat  out  1  result was clamped; qualified by out_valid
busy  out  1  OR of all stage valid bits

Behaviour:
- Reset: ap_rst asynchronous and active-high.
  - Clears every stage valid bit and every stage data register.
  - out_valid=0, dout=0, out_sat=0, busy=0 while ap_rst is high; in_ready=0 while ap_rst is high.
  - Reset mid-operation discards all in-flight beats; none are emitted after reset.
- Transfers: an input transfer occurs when in_valid&in_ready; an output transfer occurs when out_valid&out_ready.
- Pipeline: stage k (k=0..NUM_STAGE-1) has a valid bit v[k].
  - adv[NUM_STAGE-1] = !v[last] | out_ready; adv[k] = !v[k] | adv[k+1].
  - in_ready = adv[0], which is combinational from out_ready. No combinational path from in_valid to out_valid.
  - When adv[k] is true, stage k loads the contents of stage k-1 (stage 0 loads the input beat); otherwise it holds.
- Latency: exactly NUM_STAGE cycles from input transfer to out_valid with out_ready held high. Throughput is 1 beat/cycle.
- Ordering: strict FIFO order. No beat is lost or duplicated under any out_ready pattern.
- Stall: while out_valid=1 and out_ready=0, dout and out_sat hold stable.
- Arithmetic, performed in stage 0:
  - Sign-extend each operand by its in_signed bit (zero-extend if unsigned) to width+1.
  - Signed multiply gives a product P of width P_W=din0_WIDTH+din1_WIDTH+2.
  - The result is signed if either in_signed bit is set.
- Rounding and shift, in stage 1 (merged into stage 0 when NUM_STAGE=1):
  - If SHIFT>0: R = (P + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift. If SHIFT=0: R = P.
- Saturation:
  - Signed result: clamp R to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
  - Unsigned result: clamp to [0, 2^dout_WIDTH-1].
  - out_sat=1 iff a clamp occurred.
  - With the defaults (unsigned, SHIFT=0), out_sat never asserts and the result equals the full 50-bit product.
- Remaining stages: pure delay registers.
- Simultaneous input and output transfer with a full pipe: both occur in the same cycle and occupancy is unchanged.

Decomposition:
- Package norm2_mul_pkg:
  - function prod_width(w0,w1)
  - function sat_round(P, signed_res, SHIFT, dout_WIDTH), returning {sat, value}
  - localparams for min/max clamp constants
- Sub-module norm2_mul_stage: one valid+data register with adv input, async reset, and width parameter; instantiated NUM_STAGE times via generate.

Test Plan:
Tests 1–4 override the parameters to din0_WIDTH=8, din1_WIDTH=8, dout_WIDTH=8, SHIFT=4, NUM_STAGE=3.
1. Unsigned 16*3, out_ready=1 -> dout=3 (56>>4), out_sat=0, out_valid exactly 3 cycles after accept. Unsigned 200*100 -> dout=255, out_sat=1.
2. Signed din0=0xFD (-3) * din1=5, in_signed=2'b11 -> dout=0xFF (-1), out_sat=0. Signed -128*-128 -> dout=0x7F, out_sat=1.
3. Stream 10 back-to-back beats while toggling out_ready 1,0,0,1 -> all 10 results emitted in order, no loss or duplication; dout stable during each stall; in_ready=0 only when the pipe is full and out_ready=0.
4. Assert ap_rst asynchronously (between clock edges) with 3 beats in flight -> out_valid, busy and dout go to 0 immediately; after release, no stale result appears and the next beat has 3-cycle latency.
5. Default parameters: din0=2^44-1, din1=63, unsigned -> dout=(2^44-1)*63, out_sat=0.
6. NUM_STAGE=1 and NUM_STAGE=8 builds: a single beat shows latency 1 and 8 respectively; full throughput holds with out_ready=1.
